// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback stage and a long-latency unit (MUL/DIV, refill) whose results
// come back out of band. Long-latency results wait in a small FIFO. Pipeline
// writeback normally has priority. If the FIFO head has been blocked for
// STARVE_MAX cycles, the arbiter holds the writeback stage for one cycle so
// the head can drain. A 32-entry busy scoreboard tracks registers that have
// an outstanding long-latency write, so decode can stall on RAW/WAW hazards.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   RegWriteW/RD_W/ResultW   pipeline writeback request
//   lu_issue/lu_issue_rd     long-latency op dispatched (marks rd busy)
//   lu_valid/lu_rd/lu_data   long-latency result offered to the FIFO
//   lu_ready                 FIFO has room (depends on occupancy only)
//   RS1_D/RS2_D/RD_D         decode operands checked against the scoreboard
//   StallD_LU                decode must stall
//   HoldW                    writeback stage must keep its inputs stable
//   rf_we/rf_rd/rf_wd        registered register-file write port
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RD_W,
  input  logic [31:0] ResultW,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RD_D,
  output logic        StallD_LU,
  output logic        HoldW,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd
);

  localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW  = $clog2(DEPTH + 1);
  localparam int WaitW = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifoRd   [DEPTH];
  logic [31:0]      fifoData [DEPTH];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic [CntW-1:0]  count;
  logic [WaitW-1:0] waitCnt;
  logic [31:0]      busy;
  logic [31:0]      busyNext;

  logic       fifoEmpty;
  logic       fifoFull;
  logic       pipeReq;
  logic       doPush;
  logic       doPop;
  logic [4:0] headRd;
  logic [31:0] headData;

  // Occupancy flags and request decode. lu_ready deliberately ignores a
  // same-cycle pop so it is a pure function of registered occupancy.
  // HoldW only ever asserts with a non-empty FIFO because waitCnt is
  // cleared whenever the FIFO is empty.
  always_comb begin
    fifoEmpty = (count == '0);
    fifoFull  = (count == CntW'(DEPTH));
    lu_ready  = !fifoFull;
    pipeReq   = RegWriteW && (RD_W != 5'd0);
    HoldW     = (waitCnt == WaitW'(STARVE_MAX));
    headRd    = fifoRd[rdPtr];
    headData  = fifoData[rdPtr];
    doPush    = lu_valid && !fifoFull;
    doPop     = !fifoEmpty && (HoldW || !pipeReq);
  end

  // Scoreboard update: a pop retires its destination, an issue marks its
  // destination busy. The issue is applied last so it wins when both hit
  // the same register. Register 0 can never be busy.
  always_comb begin
    busyNext = busy;
    if (doPop && (headRd != 5'd0)) begin
      busyNext[headRd] = 1'b0;
    end
    if (lu_issue && (lu_issue_rd != 5'd0)) begin
      busyNext[lu_issue_rd] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Decode hazard check against registered busy bits, so an issue becomes
  // visible to decode one cycle later. Index 0 always reads as not busy.
  always_comb begin
    StallD_LU = ((RS1_D != 5'd0) && busy[RS1_D]) ||
                ((RS2_D != 5'd0) && busy[RS2_D]) ||
                ((RD_D  != 5'd0) && busy[RD_D]);
  end

  // FIFO storage needs no reset: entries are only read when occupancy says
  // they were written, and reset clears occupancy.
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoRd[wrPtr]   <= lu_rd;
      fifoData[wrPtr] <= lu_data;
    end
  end

  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally. A simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts edges where the FIFO head lost arbitration
  // to the pipeline. Any pop, or an empty FIFO, restarts the count. Once it
  // reaches STARVE_MAX, HoldW forces the next grant to the FIFO, which pops
  // and clears it again, so the count never passes STARVE_MAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt <= '0;
    end else if (doPop || fifoEmpty) begin
      waitCnt <= '0;
    end else if (pipeReq && !HoldW) begin
      waitCnt <= waitCnt + WaitW'(1);
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Registered write port. A popped head aimed at x0 is discarded with
  // rf_we low. Address and data only change when a real write goes out, so
  // they keep their last values on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we <= 1'b0;
      rf_rd <= 5'd0;
      rf_wd <= 32'd0;
    end else if (doPop) begin
      rf_we <= (headRd != 5'd0);
      if (headRd != 5'd0) begin
        rf_rd <= headRd;
        rf_wd <= headData;
      end
    end else if (pipeReq) begin
      rf_we <= 1'b1;
      rf_rd <= RD_W;
      rf_wd <= ResultW;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Self-checking bench for wb_port_arbiter. A behavioural model holds the
// pending long-latency results in a queue, keeps busy flags in a plain
// vector, and counts how long the queue head has been passed over. Each
// cycle it predicts HoldW, lu_ready, StallD_LU and the registered write
// port. Directed sequences are followed by a long randomized run. The
// stimulus obeys the producer handshakes: results are held until accepted,
// and writeback inputs stay stable after a HoldW cycle.
module tb_wb_port_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] ResultW;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  RS1_D;
  logic [4:0]  RS2_D;
  logic [4:0]  RD_D;
  logic        StallD_LU;
  logic        HoldW;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D), .StallD_LU(StallD_LU),
    .HoldW(HoldW), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [36:0] mq[$];
  logic [31:0] mBusy;
  int          mStarve;
  logic        mWe;
  logic [4:0]  mRd;
  logic [31:0] mWd;
  logic        lastHold;
  logic        pendingLu;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mBusy     = '0;
    mStarve   = 0;
    mWe       = 1'b0;
    mRd       = 5'd0;
    mWd       = 32'd0;
    lastHold  = 1'b0;
    pendingLu = 1'b0;
  endtask

  function automatic logic modelStall();
    return ((RS1_D != 0) && mBusy[RS1_D]) || ((RS2_D != 0) && mBusy[RS2_D]) ||
           ((RD_D != 0) && mBusy[RD_D]);
  endfunction

  // One clock cycle: check the combinational outputs against the model,
  // let the edge happen, advance the model from the inputs in force at the
  // edge, then check the registered write port. Entered just after a
  // rising edge; it returns one time unit after the next rising edge.
  task automatic stepCycle();
    logic        expHold, expReady, pw, grantLu, doPush, wasEmpty;
    logic [36:0] head;
    #1;
    expHold  = (mStarve == STARVE_MAX);
    expReady = (mq.size() < DEPTH);
    checkOutput("HoldW", HoldW, expHold);
    checkOutput("lu_ready", lu_ready, expReady);
    checkOutput("StallD_LU", StallD_LU, modelStall());
    pw       = RegWriteW && (RD_W != 5'd0);
    doPush   = lu_valid && expReady;
    wasEmpty = (mq.size() == 0);
    grantLu  = !wasEmpty && (expHold || !pw);
    @(posedge clk);
    #1;
    if (grantLu) begin
      head = mq.pop_front();
      if (head[36:32] != 5'd0) begin
        mWe = 1'b1;
        mRd = head[36:32];
        mWd = head[31:0];
        mBusy[head[36:32]] = 1'b0;
      end else begin
        mWe = 1'b0;
      end
    end else if (pw) begin
      mWe = 1'b1;
      mRd = RD_W;
      mWd = ResultW;
    end else begin
      mWe = 1'b0;
    end
    if (grantLu || wasEmpty) mStarve = 0;
    else if (pw && !expHold) mStarve++;
    if (lu_issue && (lu_issue_rd != 5'd0)) mBusy[lu_issue_rd] = 1'b1;
    if (doPush) mq.push_back({lu_rd, lu_data});
    lastHold  = expHold;
    pendingLu = lu_valid && !expReady;
    checkOutput("rf_we", rf_we, mWe);
    checkOutput("rf_rd", rf_rd, mRd);
    checkOutput("rf_wd", rf_wd, mWd);
  endtask

  // Random inputs, respecting the hold and lu handshakes.
  task automatic applyStimulus();
    if (!lastHold) begin
      RegWriteW = ($urandom_range(0, 9) < 7);
      RD_W      = 5'($urandom_range(0, 31));
      ResultW   = $urandom;
    end
    if (!pendingLu) begin
      lu_valid = ($urandom_range(0, 9) < 4);
      lu_rd    = 5'($urandom_range(0, 7));
      lu_data  = $urandom;
    end
    lu_issue    = ($urandom_range(0, 9) < 3);
    lu_issue_rd = 5'($urandom_range(0, 7));
    RS1_D       = 5'($urandom_range(0, 7));
    RS2_D       = 5'($urandom_range(0, 7));
    RD_D        = 5'($urandom_range(0, 7));
  endtask

  task automatic idleInputs();
    RegWriteW = 1'b0; RD_W = 5'd0; ResultW = 32'd0;
    lu_issue = 1'b0; lu_issue_rd = 5'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    RS1_D = 5'd0; RS2_D = 5'd0; RD_D = 5'd0;
  endtask

  initial begin
    logic       sawBeef;
    int         popIdx;
    int         k;
    int         gotCnt;
    logic [4:0] gotOrder [3];

    idleInputs();
    modelReset();
    RS1_D = 5'd7;
    #3;
    checkOutput("reset_rf_we", rf_we, 1'b0);
    checkOutput("reset_rf_rd", rf_rd, 5'd0);
    checkOutput("reset_rf_wd", rf_wd, 32'd0);
    checkOutput("reset_HoldW", HoldW, 1'b0);
    checkOutput("reset_lu_ready", lu_ready, 1'b1);
    checkOutput("reset_stall", StallD_LU, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Pipeline write with an empty FIFO, then a write to x0
    RegWriteW = 1'b1; RD_W = 5'd5; ResultW = 32'hA5A5A5A5;
    stepCycle();
    checkOutput("idle_we", rf_we, 1'b1);
    checkOutput("idle_rd", rf_rd, 5'd5);
    checkOutput("idle_wd", rf_wd, 32'hA5A5A5A5);
    RD_W = 5'd0;
    stepCycle();
    checkOutput("x0_we", rf_we, 1'b0);
    RegWriteW = 1'b0;

    // Single long-latency result through an idle pipeline
    lu_issue = 1'b1; lu_issue_rd = 5'd7; RS1_D = 5'd7;
    stepCycle();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
    stepCycle();
    checkOutput("lu_stall_pending", StallD_LU, 1'b1);
    lu_valid = 1'b0;
    stepCycle();
    checkOutput("lu_we", rf_we, 1'b1);
    checkOutput("lu_rd", rf_rd, 5'd7);
    checkOutput("lu_wd", rf_wd, 32'h1234);
    #1;
    checkOutput("lu_busy_cleared", StallD_LU, 1'b0);
    stepCycle();
    RS1_D = 5'd0;

    // Contention: pipeline writes every cycle while (9, 0xBEEF) waits
    RegWriteW = 1'b1; RD_W = 5'd1; ResultW = 32'd1;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hBEEF;
    stepCycle();
    lu_valid = 1'b0;
    sawBeef = 1'b0;
    popIdx = -1;
    for (int i = 0; i < 8; i++) begin
      if (!lastHold) begin
        RD_W = 5'(10 + i);
        ResultW = 32'(i);
      end
      stepCycle();
      if (!sawBeef && rf_we && (rf_rd == 5'd9) && (rf_wd == 32'hBEEF)) begin
        sawBeef = 1'b1;
        popIdx = i;
      end
    end
    checkOutput("contention_pop_seen", sawBeef, 1'b1);
    checkOutput("contention_pop_cycle", popIdx, 4);
    RegWriteW = 1'b0;
    stepCycle();

    // Full FIFO: three results against a busy pipeline, order must hold
    k = 0;
    gotCnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!lastHold) begin
        RegWriteW = (i < 16);
        RD_W = 5'(20 + (i % 8));
        ResultW = 32'(i);
      end
      if (!pendingLu) begin
        if (k < 3) begin
          lu_valid = 1'b1;
          lu_rd = 5'(11 + k);
          lu_data = 32'hC000 + 32'(k);
          k++;
        end else begin
          lu_valid = 1'b0;
        end
      end
      if (i == 2) begin
        #1;
        checkOutput("full_lu_ready", lu_ready, 1'b0);
      end
      stepCycle();
      if (rf_we && (rf_rd >= 5'd11) && (rf_rd <= 5'd13) && (gotCnt < 3)) begin
        gotOrder[gotCnt] = rf_rd;
        gotCnt++;
      end
    end
    checkOutput("full_write_count", gotCnt, 3);
    for (int j = 0; j < 3; j++) begin
      if (j < gotCnt) checkOutput("full_order", gotOrder[j], 5'(11 + j));
    end
    idleInputs();
    stepCycle();

    // Set and clear of register 3 on the same edge: set wins
    lu_issue = 1'b1; lu_issue_rd = 5'd3;
    stepCycle();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
    stepCycle();
    lu_valid = 1'b0;
    lu_issue = 1'b1; lu_issue_rd = 5'd3;
    stepCycle();
    lu_issue = 1'b0;
    RS2_D = 5'd3;
    #1;
    checkOutput("collide_stall", StallD_LU, 1'b1);
    stepCycle();

    // Asynchronous reset with two results buffered and busy bits set
    RegWriteW = 1'b1; RD_W = 5'd2; ResultW = 32'h2;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h3003;
    lu_issue = 1'b1; lu_issue_rd = 5'd4;
    stepCycle();
    RD_W = 5'd5; ResultW = 32'h5;
    lu_rd = 5'd4; lu_data = 32'h4004; lu_issue_rd = 5'd6;
    stepCycle();
    lu_valid = 1'b0; lu_issue = 1'b0;
    RS1_D = 5'd4; RS2_D = 5'd6; RD_D = 5'd3;
    #1;
    checkOutput("prereset_lu_ready", lu_ready, 1'b0);
    checkOutput("prereset_stall", StallD_LU, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_rf_we", rf_we, 1'b0);
    checkOutput("midreset_rf_rd", rf_rd, 5'd0);
    checkOutput("midreset_lu_ready", lu_ready, 1'b1);
    checkOutput("midreset_stall", StallD_LU, 1'b0);
    checkOutput("midreset_HoldW", HoldW, 1'b0);
    modelReset();
    RegWriteW = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("postreset_no_write", rf_we, 1'b0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
